// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter/sequencer for an asynchronous SRAM; every strobe comes straight from a flop.
// Latency from the IDLE cycle that sees a REQ: write 3 cycles, read RD_CYCLES+1 cycles; REQ must be held until its ACK.
module sram_arbiter #(
    parameter int DEPTH     = 12,
    parameter int WIDTH     = 8,
    parameter int RD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             wr0,
    input  logic             wr1,
    input  logic [DEPTH-1:0] addr0,
    input  logic [DEPTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic [DEPTH-1:0] sram_addr,
    output logic [WIDTH-1:0] sram_wdata,
    output logic             sram_n_we,
    output logic             sram_n_oe,
    input  logic [WIDTH-1:0] sram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        RD_ACCESS,
        RD_DONE
    } state_t;

    localparam int CW = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
    localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant_nxt;
    logic [CW-1:0]    rd_cnt;
    logic [CW-1:0]    rd_cnt_nxt;
    logic [DEPTH-1:0] addr_nxt;
    logic [WIDTH-1:0] wdata_nxt;
    logic [WIDTH-1:0] rdata_nxt;
    logic             wr_sel;
    logic             done_nxt;

    always_comb begin
        state_nxt  = state;
        grant_nxt  = last_grant;
        rd_cnt_nxt = rd_cnt;
        addr_nxt   = sram_addr;
        wdata_nxt  = sram_wdata;
        rdata_nxt  = rdata;
        wr_sel     = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port that did not win last time goes next.
                    if (req0 && req1) begin
                        grant_nxt = ~last_grant;
                    end else begin
                        grant_nxt = req1;
                    end
                    addr_nxt   = grant_nxt ? addr1  : addr0;
                    wdata_nxt  = grant_nxt ? wdata1 : wdata0;
                    wr_sel     = grant_nxt ? wr1    : wr0;
                    rd_cnt_nxt = '0;
                    state_nxt  = wr_sel ? WR_SETUP : RD_ACCESS;
                end
            end
            WR_SETUP:  state_nxt = WR_STROBE;
            WR_STROBE: state_nxt = WR_HOLD;
            WR_HOLD:   state_nxt = IDLE;
            RD_ACCESS: begin
                if (rd_cnt == RD_LAST) begin
                    rdata_nxt = sram_rdata;
                    state_nxt = RD_DONE;
                end else begin
                    rd_cnt_nxt = rd_cnt + 1'b1;
                end
            end
            RD_DONE:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Strobes and ACKs are decoded from the next state so they switch with the state flops, glitch-free.
    assign done_nxt = (state_nxt == WR_HOLD) || (state_nxt == RD_DONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rd_cnt     <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rdata      <= '0;
            sram_n_we  <= 1'b1;
            sram_n_oe  <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= grant_nxt;
            rd_cnt     <= rd_cnt_nxt;
            sram_addr  <= addr_nxt;
            sram_wdata <= wdata_nxt;
            rdata      <= rdata_nxt;
            sram_n_we  <= (state_nxt != WR_STROBE);
            sram_n_oe  <= (state_nxt != RD_ACCESS);
            ack0       <= done_nxt && !grant_nxt;
            ack1       <= done_nxt && grant_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: two arbiters (RD_CYCLES=2 and RD_CYCLES=1), each driving a behavioural async SRAM.
module tb_sram_arbiter;

    logic        clk;
    logic        n_rst;

    logic        req0, req1, wr0, wr1;
    logic [11:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        ack0, ack1, busy;
    logic [7:0]  rdata;
    logic [11:0] s_addr;
    logic [7:0]  s_wdata, s_rdata;
    logic        s_n_we, s_n_oe;

    logic        b_req0, b_wr0;
    logic [11:0] b_addr0;
    logic [7:0]  b_wdata0;
    logic        b_ack0, b_ack1, b_busy;
    logic [7:0]  b_rdata;
    logic [11:0] b_s_addr;
    logic [7:0]  b_s_wdata, b_s_rdata;
    logic        b_s_n_we, b_s_n_oe;

    logic [7:0]  mem_a [4096];
    logic [7:0]  mem_b [4096];

    int total = 0;
    int bad = 0;
    int we_low = 0, oe_low = 0, b_oe_low = 0;
    int ack_total = 0, overlap = 0, viol = 0;

    sram_arbiter #(.DEPTH(12), .WIDTH(8), .RD_CYCLES(2)) u_a (
        .clk(clk), .n_rst(n_rst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .sram_addr(s_addr), .sram_wdata(s_wdata),
        .sram_n_we(s_n_we), .sram_n_oe(s_n_oe), .sram_rdata(s_rdata)
    );

    sram_arbiter #(.DEPTH(12), .WIDTH(8), .RD_CYCLES(1)) u_b (
        .clk(clk), .n_rst(n_rst),
        .req0(b_req0), .req1(1'b0), .wr0(b_wr0), .wr1(1'b0),
        .addr0(b_addr0), .addr1(12'h000), .wdata0(b_wdata0), .wdata1(8'h00),
        .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .busy(b_busy),
        .sram_addr(b_s_addr), .sram_wdata(b_s_wdata),
        .sram_n_we(b_s_n_we), .sram_n_oe(b_s_n_oe), .sram_rdata(b_s_rdata)
    );

    // Asynchronous SRAM models: latch on the N_WE falling edge, drive data while N_OE is low.
    always @(negedge s_n_we) mem_a[s_addr] <= s_wdata;
    always @(negedge b_s_n_we) mem_b[b_s_addr] <= b_s_wdata;
    assign s_rdata   = s_n_oe   ? 8'h00 : mem_a[s_addr];
    assign b_s_rdata = b_s_n_oe ? 8'h00 : mem_b[b_s_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!s_n_we) we_low++;
        if (!s_n_oe) oe_low++;
        if (!b_s_n_oe) b_oe_low++;
        if (ack0 | ack1) ack_total++;
        if (ack0 & ack1) overlap++;
        if ((!s_n_we && !s_n_oe) || (!b_s_n_we && !b_s_n_oe)) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on DUT a from a falling edge; return ACK latency and strobe-low cycle counts.
    task automatic run_a(input bit p, input bit wr, input logic [11:0] a, input logic [7:0] d,
                         output int lat, output int we_n, output int oe_n);
        int we0, oe0;
        bit seen;
        we0 = we_low; oe0 = oe_low; lat = 0; seen = 1'b0;
        if (!p) begin req0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = d; end
        else    begin req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = d; end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (p ? ack1 : ack0) begin
                seen = 1'b1;
                chk("ack_other_idle", p ? ack0 : ack1, 1'b0);
            end
        end
        if (!seen) chk("ack_timeout", 0, 1);
        if (!p) req0 = 1'b0; else req1 = 1'b0;
        we_n = we_low - we0;
        oe_n = oe_low - oe0;
    endtask

    task automatic run_b(input bit wr, input logic [11:0] a, input logic [7:0] d,
                         output int lat, output int oe_n);
        int oe0;
        bit seen;
        oe0 = b_oe_low; lat = 0; seen = 1'b0;
        b_req0 = 1'b1; b_wr0 = wr; b_addr0 = a; b_wdata0 = d;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (b_ack0) seen = 1'b1;
        end
        if (!seen) chk("b_ack_timeout", 0, 1);
        b_req0 = 1'b0;
        oe_n = b_oe_low - oe0;
    endtask

    initial begin
        int lat, we_n, oe_n, ack_snap;
        int order[$];
        n_rst = 1'b0;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        b_req0 = 0; b_wr0 = 0; b_addr0 = '0; b_wdata0 = '0;
        repeat (2) @(negedge clk);

        chk("rst_n_we", s_n_we, 1'b1);
        chk("rst_n_oe", s_n_oe, 1'b1);
        chk("rst_ack0", ack0, 1'b0);
        chk("rst_ack1", ack1, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_addr", s_addr, 12'h000);
        chk("rst_wdata", s_wdata, 8'h00);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Port 0 write
        run_a(1'b0, 1'b1, 12'h010, 8'h5A, lat, we_n, oe_n);
        chk("wr_lat", lat, 3);
        chk("wr_we_cycles", we_n, 1);
        chk("wr_hold_addr", s_addr, 12'h010);
        chk("wr_hold_wdata", s_wdata, 8'h5A);
        chk("wr_mem", mem_a[12'h010], 8'h5A);
        @(negedge clk);
        chk("wr_ack_pulse", ack0, 1'b0);
        chk("wr_idle_busy", busy, 1'b0);

        // Port 1 read of the same address
        run_a(1'b1, 1'b0, 12'h010, 8'h00, lat, we_n, oe_n);
        chk("rd_lat", lat, 3);
        chk("rd_oe_cycles", oe_n, 2);
        chk("rd_data", rdata, 8'h5A);
        repeat (2) @(negedge clk);
        chk("rd_ack_pulse", ack1, 1'b0);
        chk("rd_hold", rdata, 8'h5A);

        // Both ports requesting continuously
        req0 = 1'b1; wr0 = 1'b1; addr0 = 12'h020; wdata0 = 8'h11;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 12'h010;
        for (int i = 0; i < 60 && order.size() < 4; i++) begin
            @(negedge clk);
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_count", order.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rr_grant%0d", k), (k < order.size()) ? order[k] : 9, k % 2);
        chk("rr_rdata", rdata, 8'h5A);
        chk("rr_mem", mem_a[12'h020], 8'h11);
        repeat (2) @(negedge clk);

        // Back-to-back write then read on port 0 at the top address
        run_a(1'b0, 1'b1, 12'hFFF, 8'h3C, lat, we_n, oe_n);
        chk("b2b_wr_lat", lat, 3);
        run_a(1'b0, 1'b0, 12'hFFF, 8'h00, lat, we_n, oe_n);
        chk("b2b_rd_lat_idle_gap", lat, 4);
        chk("b2b_rdata", rdata, 8'h3C);
        repeat (2) @(negedge clk);

        // Reset asserted during the write strobe
        req0 = 1'b1; wr0 = 1'b1; addr0 = 12'h100; wdata0 = 8'h77;
        repeat (2) @(negedge clk);
        chk("mid_strobe_low", s_n_we, 1'b0);
        ack_snap = ack_total;
        #2 n_rst = 1'b0;
        req0 = 1'b0;
        #1;
        chk("rst_we_async", s_n_we, 1'b1);
        chk("rst_busy_async", busy, 1'b0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        chk("rst_no_ack", ack_total - ack_snap, 0);
        chk("rst_rdata_clear", rdata, 8'h00);
        @(negedge clk);
        run_a(1'b0, 1'b0, 12'h010, 8'h00, lat, we_n, oe_n);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_rdata", rdata, 8'h5A);

        // RD_CYCLES=1 instance
        run_b(1'b1, 12'h000, 8'hC3, lat, oe_n);
        chk("b_wr_lat", lat, 3);
        @(negedge clk);
        run_b(1'b0, 12'h000, 8'h00, lat, oe_n);
        chk("b_rd_lat", lat, 2);
        chk("b_rd_oe_cycles", oe_n, 1);
        chk("b_rdata", b_rdata, 8'hC3);

        chk("we_oe_exclusive", viol, 0);
        chk("ack_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
